mem_stage: RTL and testbench

Memory-access stage of the 16-bit pipelined CPU. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It owns the word-addressed data RAM and performs loads and stores with a parameterised access latency. While an access is in flight it stalls the upstream pipeline and presents a bubble downstream. Non-memory instructions pass straight through with no added latency.

---
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage.sv | 125 ++++++++++++
 tb/tb_mem_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bus between the EX/MEM pipeline register and the memory-access stage.
// The master modport is the pipeline side. The slave modport is mem_stage.
interface mem_stage_if;
  // EX/MEM -> memory stage
  logic [15:0] alu_result_in;
  logic [15:0] store_data_in;
  logic [3:0]  rd_in;
  logic        reg_write_in;
  logic        mem_read_in;
  logic        mem_write_in;

  // memory stage -> MEM/WB and hazard control
  logic [15:0] mem_data_out;
  logic [15:0] alu_result_out;
  logic [3:0]  rd_out;
  logic        reg_write_out;
  logic        stall_out;
  logic        fault_out;

  modport master (
    output alu_result_in, store_data_in, rd_in, reg_write_in, mem_read_in, mem_write_in,
    input  mem_data_out, alu_result_out, rd_out, reg_write_out, stall_out, fault_out
  );

  modport slave (
    input  alu_result_in, store_data_in, rd_in, reg_write_in, mem_read_in, mem_write_in,
    output mem_data_out, alu_result_out, rd_out, reg_write_out, stall_out, fault_out
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the 16-bit pipelined CPU.
// - Owns the word-addressed data RAM.
// - Performs each load or store with a fixed wait of WAIT_CYCLES.
// - Stalls upstream while an access is in flight.
// - Non-memory instructions pass through with no added latency.
module mem_stage #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2   // legal range 0..15
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  localparam int          DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic [15:0]            rdata_q;
  logic                   fault_q;

  logic [15:0]            ram [DEPTH];

  logic                   mem_op;
  logic                   out_of_range;
  logic                   illegal;
  logic                   commit;
  logic                   ram_we;
  logic [15:0]            addr_high;
  logic [ADDR_BITS-1:0]   idx;

  // Decode the access and its legality from the held EX/MEM inputs.
  assign mem_op       = bus.mem_read_in | bus.mem_write_in;
  assign addr_high    = bus.alu_result_in >> ADDR_BITS;
  assign out_of_range = (addr_high != 16'h0000);
  assign illegal      = out_of_range | (bus.mem_read_in & bus.mem_write_in);
  assign idx          = bus.alu_result_in[ADDR_BITS-1:0];

  // The access commits on the edge that ends the last BUSY cycle.
  // While reset is high the FSM sits in IDLE, so a pending store is dropped.
  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);
  assign ram_we = commit & bus.mem_write_in & ~illegal;

  // Access FSM. It times the wait and registers the load data and the fault flag.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 16'h0000;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            state_q <= BUSY;
            cnt_q   <= WAIT_LOAD;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= DONE;
            // Stores and illegal accesses return zero.
            rdata_q <= (bus.mem_read_in && !illegal) ? ram[idx] : 16'h0000;
            fault_q <= illegal;
          end
        end
        DONE: begin
          state_q <= IDLE;
          fault_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Data RAM write port.
  // NOTE: the RAM array has no reset. Its contents persist across reset, and leaving it unreset lets it map to RAM macros.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx] <= bus.store_data_in;
    end
  end

  // Output decode. Reset forces the control outputs to their idle values.
  // NOTE: every output gets a default first, so no path through the block infers a latch.
  always_comb begin
    bus.stall_out     = 1'b0;
    bus.reg_write_out = 1'b0;
    bus.mem_data_out  = 16'h0000;
    bus.fault_out     = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          bus.stall_out     = mem_op;
          bus.reg_write_out = bus.reg_write_in & ~mem_op;
        end
        BUSY: begin
          bus.stall_out = 1'b1;
        end
        DONE: begin
          bus.reg_write_out = bus.reg_write_in;
          bus.mem_data_out  = rdata_q;
          bus.fault_out     = fault_q;
        end
        default: begin
          bus.stall_out = 1'b0;
        end
      endcase
    end
  end

  // The pass-through fields are combinational copies in every state, including reset.
  assign bus.alu_result_out = bus.alu_result_in;
  assign bus.rd_out         = bus.rd_in;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage.
// Instance dut_a uses WAIT_CYCLES=2. Instance dut_b uses WAIT_CYCLES=0.
// The sel signal routes the stimulus to one instance and selects which outputs are observed.
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset;
  logic sel;          // 0: dut_a (WAIT=2), 1: dut_b (WAIT=0)
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] t_alu, t_sd;
  logic [3:0]  t_rd;
  logic        t_rw, t_mr, t_mw;

  logic [15:0] o_data, o_alu;
  logic [3:0]  o_rd;
  logic        o_rw, o_stall, o_fault;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_if bus_a ();
  mem_stage_if bus_b ();

  assign bus_a.alu_result_in = sel ? 16'h0 : t_alu;
  assign bus_a.store_data_in = sel ? 16'h0 : t_sd;
  assign bus_a.rd_in         = sel ? 4'h0  : t_rd;
  assign bus_a.reg_write_in  = sel ? 1'b0  : t_rw;
  assign bus_a.mem_read_in   = sel ? 1'b0  : t_mr;
  assign bus_a.mem_write_in  = sel ? 1'b0  : t_mw;
  assign bus_b.alu_result_in = sel ? t_alu : 16'h0;
  assign bus_b.store_data_in = sel ? t_sd  : 16'h0;
  assign bus_b.rd_in         = sel ? t_rd  : 4'h0;
  assign bus_b.reg_write_in  = sel ? t_rw  : 1'b0;
  assign bus_b.mem_read_in   = sel ? t_mr  : 1'b0;
  assign bus_b.mem_write_in  = sel ? t_mw  : 1'b0;

  assign o_data  = sel ? bus_b.mem_data_out   : bus_a.mem_data_out;
  assign o_alu   = sel ? bus_b.alu_result_out : bus_a.alu_result_out;
  assign o_rd    = sel ? bus_b.rd_out         : bus_a.rd_out;
  assign o_rw    = sel ? bus_b.reg_write_out  : bus_a.reg_write_out;
  assign o_stall = sel ? bus_b.stall_out      : bus_a.stall_out;
  assign o_fault = sel ? bus_b.fault_out      : bus_a.fault_out;

  mem_stage #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  mem_stage #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic set_idle();
    t_alu = 16'h0; t_sd = 16'h0; t_rd = 4'h0;
    t_rw = 1'b0; t_mr = 1'b0; t_mw = 1'b0;
  endtask

  // Presents one memory op and holds it until the DONE cycle.
  // Returns the stall count and the DONE-cycle outputs, then drops the op after the DONE edge.
  // A missing DONE within the bound is reported as stalls = -1.
  task automatic run_op(input logic rd_en, input logic wr_en, input logic [15:0] addr,
                        input logic [15:0] data, input logic [3:0] rd, input logic rw,
                        output int stalls, output logic rw_leak, output logic [15:0] mdata,
                        output logic flt, output logic [3:0] rdo, output logic rwo,
                        output int done_cyc);
    logic done;
    stalls = 0; rw_leak = 1'b0; done = 1'b0;
    mdata = 'x; flt = 1'bx; rdo = 'x; rwo = 1'bx; done_cyc = -1;
    t_alu = addr; t_sd = data; t_rd = rd; t_rw = rw; t_mr = rd_en; t_mw = wr_en;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (o_stall === 1'b1) begin
        stalls++;
        if (o_rw !== 1'b0) rw_leak = 1'b1;
        @(posedge clk); #1;
      end else begin
        mdata = o_data; flt = o_fault; rdo = o_rd; rwo = o_rw; done_cyc = cyc;
        done = 1'b1;
      end
    end
    if (!done) stalls = -1;
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_reset();
    sel = 1'b0;
    t_alu = 16'hCAFE; t_rd = 4'd9; t_rw = 1'b1; t_mr = 1'b1;
    #2;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %h expected 0", o_stall); end
    checks++; if (o_rw !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %h expected 0", o_rw); end
    checks++; if (o_data !== 16'h0) begin errors++; $display("FAIL reset_mem_data: got %h expected 0000", o_data); end
    checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %h expected 0", o_fault); end
    checks++; if (o_alu !== 16'hCAFE) begin errors++; $display("FAIL reset_alu_pass: got %h expected cafe", o_alu); end
    checks++; if (o_rd !== 4'd9) begin errors++; $display("FAIL reset_rd_pass: got %h expected 9", o_rd); end
    set_idle();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    t_alu = 16'h1234; t_rd = 4'd3; t_rw = 1'b1;
    @(negedge clk);
    checks++; if (o_alu !== 16'h1234) begin errors++; $display("FAIL pass_alu: got %h expected 1234", o_alu); end
    checks++; if (o_rd !== 4'd3) begin errors++; $display("FAIL pass_rd: got %h expected 3", o_rd); end
    checks++; if (o_rw !== 1'b1) begin errors++; $display("FAIL pass_reg_write: got %h expected 1", o_rw); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL pass_stall: got %h expected 0", o_stall); end
    checks++; if (o_data !== 16'h0) begin errors++; $display("FAIL pass_mem_data: got %h expected 0000", o_data); end
    @(posedge clk); #1;
    t_alu = 16'h4321; t_rd = 4'd7;
    @(negedge clk);
    checks++; if (o_alu !== 16'h4321) begin errors++; $display("FAIL pass_alu2: got %h expected 4321", o_alu); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL pass_stall2: got %h expected 0", o_stall); end
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_store_load();
    int s, dc; logic lk, f, w; logic [15:0] d; logic [3:0] r;
    run_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, 4'd0, 1'b0, s, lk, d, f, r, w, dc);
    checks++; if (s !== 4) begin errors++; $display("FAIL st_stalls: got %0d expected 4", s); end
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL st_mem_data: got %h expected 0000", d); end
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL st_fault: got %h expected 0", f); end
    run_op(1'b1, 1'b0, 16'h0010, 16'h0000, 4'd5, 1'b1, s, lk, d, f, r, w, dc);
    checks++; if (s !== 4) begin errors++; $display("FAIL ld_stalls: got %0d expected 4", s); end
    checks++; if (lk !== 1'b0) begin errors++; $display("FAIL ld_rw_while_stalled: got %h expected 0", lk); end
    checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL ld_mem_data: got %h expected beef", d); end
    checks++; if (r !== 4'd5) begin errors++; $display("FAIL ld_rd: got %h expected 5", r); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL ld_reg_write: got %h expected 1", w); end
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL ld_fault: got %h expected 0", f); end
  endtask

  task automatic test_out_of_range();
    int s, dc; logic lk, f, w; logic [15:0] d; logic [3:0] r;
    run_op(1'b0, 1'b1, 16'h0000, 16'h0F0F, 4'd0, 1'b0, s, lk, d, f, r, w, dc);
    run_op(1'b0, 1'b1, 16'h00FF, 16'h3C3C, 4'd0, 1'b0, s, lk, d, f, r, w, dc);
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL top_addr_fault: got %h expected 0", f); end
    run_op(1'b1, 1'b0, 16'h0100, 16'h0000, 4'd2, 1'b1, s, lk, d, f, r, w, dc);
    checks++; if (s !== 4) begin errors++; $display("FAIL oor_stalls: got %0d expected 4", s); end
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL oor_fault: got %h expected 1", f); end
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL oor_mem_data: got %h expected 0000", d); end
    @(negedge clk);
    checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL oor_fault_width: got %h expected 0", o_fault); end
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 16'h0100, 16'hDEAD, 4'd0, 1'b0, s, lk, d, f, r, w, dc);
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL oor_store_fault: got %h expected 1", f); end
    run_op(1'b1, 1'b0, 16'h0000, 16'h0000, 4'd1, 1'b1, s, lk, d, f, r, w, dc);
    checks++; if (d !== 16'h0F0F) begin errors++; $display("FAIL oor_addr0_kept: got %h expected 0f0f", d); end
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL oor_addr0_fault: got %h expected 0", f); end
    run_op(1'b1, 1'b0, 16'h00FF, 16'h0000, 4'd1, 1'b1, s, lk, d, f, r, w, dc);
    checks++; if (d !== 16'h3C3C) begin errors++; $display("FAIL top_addr_data: got %h expected 3c3c", d); end
  endtask

  task automatic test_conflict();
    int s, dc; logic lk, f, w; logic [15:0] d; logic [3:0] r;
    run_op(1'b0, 1'b1, 16'h0020, 16'h7777, 4'd0, 1'b0, s, lk, d, f, r, w, dc);
    run_op(1'b1, 1'b1, 16'h0020, 16'hAAAA, 4'd4, 1'b1, s, lk, d, f, r, w, dc);
    checks++; if (s !== 4) begin errors++; $display("FAIL rw_both_stalls: got %0d expected 4", s); end
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL rw_both_fault: got %h expected 1", f); end
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL rw_both_mem_data: got %h expected 0000", d); end
    run_op(1'b1, 1'b0, 16'h0020, 16'h0000, 4'd4, 1'b1, s, lk, d, f, r, w, dc);
    checks++; if (d !== 16'h7777) begin errors++; $display("FAIL rw_both_kept: got %h expected 7777", d); end
  endtask

  task automatic test_reset_mid_access();
    int s, dc; logic lk, f, w; logic [15:0] d; logic [3:0] r;
    run_op(1'b0, 1'b1, 16'h0030, 16'h1111, 4'd0, 1'b0, s, lk, d, f, r, w, dc);
    t_alu = 16'h0030; t_sd = 16'h5555; t_rd = 4'd6; t_rw = 1'b1; t_mw = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %h expected 1", o_stall); end
    #1 reset = 1'b1;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %h expected 0", o_stall); end
    checks++; if (o_rw !== 1'b0) begin errors++; $display("FAIL midrst_reg_write: got %h expected 0", o_rw); end
    checks++; if (o_data !== 16'h0) begin errors++; $display("FAIL midrst_mem_data: got %h expected 0000", o_data); end
    checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL midrst_fault: got %h expected 0", o_fault); end
    checks++; if (o_alu !== 16'h0030) begin errors++; $display("FAIL midrst_alu_pass: got %h expected 0030", o_alu); end
    repeat (3) @(posedge clk);
    #1 set_idle();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %h expected 0", o_stall); end
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 16'h0030, 16'h0000, 4'd6, 1'b1, s, lk, d, f, r, w, dc);
    checks++; if (s !== 4) begin errors++; $display("FAIL midrst_ld_stalls: got %0d expected 4", s); end
    checks++; if (d !== 16'h1111) begin errors++; $display("FAIL midrst_old_value: got %h expected 1111", d); end
  endtask

  task automatic test_back_to_back();
    int s1, s2, c1, c2, s, dc; logic lk, f, w; logic [15:0] d1, d2, d; logic [3:0] r;
    sel = 1'b1;
    run_op(1'b0, 1'b1, 16'h0005, 16'h1234, 4'd0, 1'b0, s, lk, d, f, r, w, dc);
    checks++; if (s !== 2) begin errors++; $display("FAIL w0_store_stalls: got %0d expected 2", s); end
    run_op(1'b0, 1'b1, 16'h0006, 16'hABCD, 4'd0, 1'b0, s, lk, d, f, r, w, dc);
    run_op(1'b1, 1'b0, 16'h0005, 16'h0000, 4'd1, 1'b1, s1, lk, d1, f, r, w, c1);
    run_op(1'b1, 1'b0, 16'h0006, 16'h0000, 4'd2, 1'b1, s2, lk, d2, f, r, w, c2);
    checks++; if (s1 !== 2) begin errors++; $display("FAIL b2b_stalls1: got %0d expected 2", s1); end
    checks++; if (s2 !== 2) begin errors++; $display("FAIL b2b_stalls2: got %0d expected 2", s2); end
    checks++; if (c2 - c1 !== 3) begin errors++; $display("FAIL b2b_done_gap: got %0d expected 3", c2 - c1); end
    checks++; if (d1 !== 16'h1234) begin errors++; $display("FAIL b2b_data1: got %h expected 1234", d1); end
    checks++; if (d2 !== 16'hABCD) begin errors++; $display("FAIL b2b_data2: got %h expected abcd", d2); end
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sel   = 1'b0;
    set_idle();
    test_reset();
    test_passthrough();
    test_store_load();
    test_out_of_range();
    test_conflict();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
